// File: rtl/text_console_writer_pkg.sv
// Shared constants and state encoding for the text console writer.
package text_console_writer_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 60;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        CLEAR_LINE = 2'd2,
        CLEAR_ALL  = 2'd3
    } state_t;

endpackage

// File: rtl/text_console_writer.sv
// Byte stream to cursor-addressed character writes for the VGA text device.
// Bus outputs are registered; in CLEAR_LINE/CLEAR_ALL one cell is written
// per cycle, so we stays high for the whole clear.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADRS_W = 13
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic [7:0]        in_char,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADRS_W-1:0] adrs,
    output logic [15:0]       data,
    output logic              we,
    output logic              cs,
    output logic              busy,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y
);

    localparam int CELLS = COLS * ROWS;
    localparam logic [15:0] SPACE_WORD = {8'h00, CH_SPACE};

    state_t            state, state_n;
    logic [6:0]        col, col_n;
    logic [5:0]        row, row_n;
    logic [ADRS_W-1:0] line_base, line_base_n;
    logic [ADRS_W-1:0] cnt, cnt_n;
    logic [ADRS_W-1:0] adrs_n;
    logic [15:0]       data_n;
    logic              we_n;
    // Set for the backspace blank write: cursor already moved, don't advance.
    logic              no_adv, no_adv_n;

    // Next-line cursor/base, wrapping from the last row back to row 0.
    logic [5:0]        nl_row;
    logic [ADRS_W-1:0] nl_base;
    logic              start_line;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign cs       = we;
    assign cursor_x = col;
    assign cursor_y = row;

    // Row/base for a move to the next line; base tracked without a multiplier.
    always_comb begin
        if (row == 6'(ROWS - 1)) begin
            nl_row  = 6'd0;
            nl_base = '0;
        end else begin
            nl_row  = row + 6'd1;
            nl_base = line_base + ADRS_W'(COLS);
        end
    end

    // Next-state, cursor and registered-bus-output computation.
    always_comb begin
        state_n     = state;
        col_n       = col;
        row_n       = row;
        line_base_n = line_base;
        cnt_n       = cnt;
        no_adv_n    = no_adv;
        we_n        = 1'b0;
        adrs_n      = adrs;
        data_n      = data;
        start_line  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_char >= CH_SPACE && in_char <= CH_TILDE) begin
                        state_n  = WRITE;
                        we_n     = 1'b1;
                        adrs_n   = line_base + ADRS_W'(col);
                        data_n   = {8'h00, in_char};
                        no_adv_n = 1'b0;
                    end else begin
                        case (in_char)
                            CH_LF: start_line = 1'b1;
                            CH_CR: col_n = 7'd0;
                            CH_BS: begin
                                if (col != 7'd0) begin
                                    col_n    = col - 7'd1;
                                    state_n  = WRITE;
                                    we_n     = 1'b1;
                                    adrs_n   = line_base + ADRS_W'(col - 7'd1);
                                    data_n   = SPACE_WORD;
                                    no_adv_n = 1'b1;
                                end
                            end
                            CH_FF: begin
                                state_n = CLEAR_ALL;
                                cnt_n   = '0;
                                we_n    = 1'b1;
                                adrs_n  = '0;
                                data_n  = SPACE_WORD;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (no_adv) begin
                    state_n = IDLE;
                end else if (col == 7'(COLS - 1)) begin
                    start_line = 1'b1;
                end else begin
                    col_n   = col + 7'd1;
                    state_n = IDLE;
                end
            end
            CLEAR_LINE: begin
                if (cnt == ADRS_W'(COLS - 1)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n  = cnt + ADRS_W'(1);
                    we_n   = 1'b1;
                    adrs_n = line_base + cnt + ADRS_W'(1);
                end
            end
            CLEAR_ALL: begin
                if (cnt == ADRS_W'(CELLS - 1)) begin
                    state_n     = IDLE;
                    col_n       = 7'd0;
                    row_n       = 6'd0;
                    line_base_n = '0;
                end else begin
                    cnt_n  = cnt + ADRS_W'(1);
                    we_n   = 1'b1;
                    adrs_n = cnt + ADRS_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // New line: home the column, step the row and blank it cell by cell.
        if (start_line) begin
            col_n       = 7'd0;
            row_n       = nl_row;
            line_base_n = nl_base;
            state_n     = CLEAR_LINE;
            cnt_n       = '0;
            we_n        = 1'b1;
            adrs_n      = nl_base;
            data_n      = SPACE_WORD;
        end
    end

    // State, cursor and bus registers; reset aborts any clear in progress.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= 7'd0;
            row       <= 6'd0;
            line_base <= '0;
            cnt       <= '0;
            no_adv    <= 1'b0;
            we        <= 1'b0;
            adrs      <= '0;
            data      <= 16'h0000;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            line_base <= line_base_n;
            cnt       <= cnt_n;
            no_adv    <= no_adv_n;
            we        <= we_n;
            adrs      <= adrs_n;
            data      <= data_n;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized and directed check of text_console_writer against a cursor model.
module tb_text_console_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int ADRS_W = 13;

    logic              cpu_clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_char = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADRS_W-1:0] adrs;
    logic [15:0]       data;
    logic              we;
    logic              cs;
    logic              busy;
    logic [6:0]        cursor_x;
    logic [5:0]        cursor_y;

    int tests = 0;
    int fails = 0;
    int wr_seen = 0;
    int mx = 0;
    int my = 0;
    int exp_a[$];
    int exp_d[$];

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADRS_W(ADRS_W)) dut (
        .cpu_clk  (cpu_clk),
        .rst      (rst),
        .in_char  (in_char),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .adrs     (adrs),
        .data     (data),
        .we       (we),
        .cs       (cs),
        .busy     (busy),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input int r);
        for (int i = 0; i < COLS; i++) begin
            exp_a.push_back(r * COLS + i);
            exp_d.push_back(32'h20);
        end
    endtask

    // Reference: screen-level effect of one byte on the cursor and write list.
    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_a.push_back(my * COLS + mx);
            exp_d.push_back(int'(c));
            if (mx < COLS - 1) mx++;
            else begin
                mx = 0;
                my = (my + 1) % ROWS;
                push_line(my);
            end
        end else if (c == 8'h0A) begin
            mx = 0;
            my = (my + 1) % ROWS;
            push_line(my);
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08) begin
            if (mx > 0) begin
                mx--;
                exp_a.push_back(my * COLS + mx);
                exp_d.push_back(32'h20);
            end
        end else if (c == 8'h0C) begin
            for (int i = 0; i < COLS * ROWS; i++) begin
                exp_a.push_back(i);
                exp_d.push_back(32'h20);
            end
            mx = 0;
            my = 0;
        end
    endtask

    // Bus monitor: every write cycle must match the next expected cell.
    always @(negedge cpu_clk) begin
        if (!rst) begin
            if (we === 1'b1) begin
                wr_seen++;
                chk("cs_during_we", 32'(cs), 32'd1);
                chk("ready_during_we", 32'(in_ready), 32'd0);
                tests++;
                assert (exp_a.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_write: observed adrs %0d data %0h expected no write", adrs, data);
                end
                if (exp_a.size() > 0) begin
                    chk("wr_adrs", 32'(adrs), exp_a.pop_front());
                    chk("wr_data", 32'(data), exp_d.pop_front());
                end
            end else begin
                chk("cs_idle", 32'(cs), 32'd0);
            end
        end
    end

    task automatic check_cursor(input string tag);
        chk({tag, "_x"}, 32'(cursor_x), mx);
        chk({tag, "_y"}, 32'(cursor_y), my);
        chk({tag, "_pending"}, exp_a.size(), 32'd0);
    endtask

    // Offer one byte when ready, then wait for the block to go idle.
    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 10000) begin
            @(negedge cpu_clk);
            n++;
        end
        model_char(c);
        in_char  = c;
        in_valid = 1'b1;
        @(posedge cpu_clk);
        #1 in_valid = 1'b0;
        @(negedge cpu_clk);
        n = 0;
        while (busy !== 1'b0 && n < 10000) begin
            @(negedge cpu_clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 10000), 32'd1);
    endtask

    initial begin
        int n;
        logic [7:0] c;

        // Reset values
        repeat (3) @(negedge cpu_clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_adrs", 32'(adrs), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        rst = 1'b0;
        @(negedge cpu_clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        check_cursor("rst_cursor");

        // Single printable character: one-cycle write, ready two cycles later
        model_char(8'h41);
        in_char  = 8'h41;
        in_valid = 1'b1;
        @(posedge cpu_clk);
        #1 in_valid = 1'b0;
        chk("A_we", 32'(we), 32'd1);
        chk("A_ready_low", 32'(in_ready), 32'd0);
        @(posedge cpu_clk);
        #1;
        chk("A_we_drop", 32'(we), 32'd0);
        chk("A_ready_back", 32'(in_ready), 32'd1);
        @(negedge cpu_clk);
        check_cursor("A_cursor");

        // Full line from column 0 wraps and blanks row 1
        send(8'h0D);
        for (int i = 0; i < COLS; i++) send(8'(8'h21 + (i % 90)));
        check_cursor("wrap_cursor");

        // Walk down to the last row, then LF wraps to row 0 without scrolling
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
        check_cursor("row59_cursor");
        send(8'h0A);
        check_cursor("row_wrap_cursor");

        // Backspace at column 5 of row 2, then at column 0
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61);
        send(8'h08);
        check_cursor("bs_cursor");
        send(8'h0D);
        send(8'h08);
        check_cursor("bs_col0_cursor");

        // Form feed clears the whole screen
        send(8'h0A);
        send(8'h33);
        wr_seen = 0;
        send(8'h0C);
        chk("ff_write_count", wr_seen, COLS * ROWS);
        check_cursor("ff_cursor");

        // Byte held valid during a line clear is taken once, after the clear
        model_char(8'h0A);
        model_char(8'h42);
        in_char  = 8'h0A;
        in_valid = 1'b1;
        @(posedge cpu_clk);
        #1 in_char = 8'h42;
        n = 0;
        forever begin
            @(negedge cpu_clk);
            if (in_ready === 1'b1 || n >= 1000) break;
            n++;
        end
        chk("hold_wait_cycles", n, 32'd80);
        @(posedge cpu_clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge cpu_clk);
        check_cursor("hold_cursor");

        // Non-printable, non-control bytes are consumed silently
        send(8'h07);
        send(8'h7F);
        check_cursor("ignored_cursor");

        // Randomized byte stream
        for (int k = 0; k < 300; k++) begin
            n = int'($urandom_range(0, 99));
            if (n < 60) c = 8'($urandom_range(32'h20, 32'h7E));
            else if (n < 68) c = 8'h0A;
            else if (n < 76) c = 8'h0D;
            else if (n < 88) c = 8'h08;
            else begin
                c = 8'($urandom_range(0, 255));
                while ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0C) c = 8'($urandom_range(0, 255));
            end
            send(c);
            check_cursor("rand");
        end

        // Reset in the middle of a full clear stops writing at once
        model_char(8'h0C);
        wr_seen  = 0;
        in_char  = 8'h0C;
        in_valid = 1'b1;
        @(posedge cpu_clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (wr_seen < 100 && n < 1000) begin
            @(negedge cpu_clk);
            n++;
        end
        chk("ff_reach_100", 32'(wr_seen >= 100), 32'd1);
        #2 rst = 1'b1;
        exp_a.delete();
        exp_d.delete();
        mx = 0;
        my = 0;
        #1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_cs", 32'(cs), 32'd0);
        chk("abort_adrs", 32'(adrs), 32'd0);
        chk("abort_data", 32'(data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge cpu_clk);
        rst = 1'b0;
        wr_seen = 0;
        repeat (20) @(negedge cpu_clk);
        chk("abort_no_writes", wr_seen, 32'd0);
        check_cursor("abort_cursor");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
